integrate_positions: RTL and testbench
======================================

INTEGRATE_POSITIONS -- requirements
Module: integrate_positions

Interface
REQ-001 SHALL have parameter NUM_NODES, default 10, node count (>=2).
REQ-002 SHALL have parameter POSITION_SIZE, default 8, signed position width.
REQ-003 SHALL have parameter VELOCITY_SIZE, default 8, signed velocity width.
REQ-004 SHALL have parameter DT, default 1, non-negative integer timestep multiplier.
REQ-005 SHALL have derived constant SUM_SIZE = POSITION_SIZE + $clog2(NUM_NODES) + 1, COM accumulator width.
REQ-006 clk_in  input  1  single clock; all logic on posedge.
REQ-007 rst_in  input  1  reset, synchronous, active-low.
REQ-008 begin_in  input  1  start pulse; samples node and velocity arrays.
REQ-009 nodes_in  input  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  current positions, index 0 = x, 1 = y.
REQ-010 velocities_in  input  signed [VELOCITY_SIZE-1:0] [1:0][NUM_NODES]  updated velocities from the wheel update stage.
REQ-011 nodes_out  output  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  integrated positions.
REQ-012 com_out  output  signed [POSITION_SIZE-1:0] [1:0]  centre of mass of nodes_out.
REQ-013 busy_out  output  1  high in every state except IDLE.
REQ-014 result_out  output  1  one-cycle done pulse.

Function
REQ-015 SHALL implement states IDLE, INTEGRATE, DIVIDE, DONE.
REQ-016 IDLE: begin_in=1 SHALL copy nodes_in/velocities_in into internal registers, clear node counter and both sums, go to INTEGRATE.
REQ-017 begin_in SHALL be ignored outside IDLE; sampled copies SHALL isolate the block from input changes mid-operation.
REQ-018 INTEGRATE SHALL process node k (k = 0..NUM_NODES-1) in cycle k, both axes in parallel, one node per cycle.
REQ-019 Per axis: p' = pos + vel*DT, evaluated at full precision (POSITION_SIZE+VELOCITY_SIZE+32 bits), signed.
REQ-020 p' SHALL saturate to [-2^(POSITION_SIZE-1), 2^(POSITION_SIZE-1)-1] before writing nodes_out[axis][k].
REQ-021 Saturated p' SHALL be sign-extended into the SUM_SIZE accumulator for that axis in the same cycle.
REQ-022 After node NUM_NODES-1, state SHALL go to DIVIDE.
REQ-023 DIVIDE: per axis, sequential restoring divide of |sum| by NUM_NODES, one quotient bit per cycle, exactly SUM_SIZE cycles, axes in parallel.
REQ-024 Quotient SHALL be negated if sum < 0 (truncate toward zero), then written to com_out[axis]; the result always fits POSITION_SIZE.
REQ-025 DONE: result_out=1 for exactly one cycle, state SHALL return to IDLE.
REQ-026 Latency: begin_in sampled at edge 0 -> result_out high in cycle NUM_NODES+SUM_SIZE+1.
REQ-027 nodes_out and com_out SHALL hold their values from the previous result until overwritten by the next operation; nodes_out entries SHALL update progressively during INTEGRATE.
REQ-028 begin_in asserted in the same cycle result_out is high SHALL be ignored; acceptance starts the following cycle (IDLE).
REQ-029 DT=0 SHALL yield nodes_out = sampled nodes_in.

Reset
REQ-030 rst_in=0 at a clock edge SHALL force IDLE and set nodes_out, com_out, result_out, busy_out, counter and sums to 0, including mid-operation.
REQ-031 The first begin_in after rst_in returns high SHALL be accepted normally; no partial prior operation SHALL affect results.

Verification (NUM_NODES=4, POSITION_SIZE=8, VELOCITY_SIZE=8; SUM_SIZE=11)
REQ-032 DT=2, x={0,10,20,30}, vx={1,2,3,4}, y=vy=0 -> nodes_out x={2,14,26,38}, com_out={20,0}, result_out high in cycle 16 only.
REQ-033 DT=1, x0=120, vx0=10; x1=-120, vx1=-20 -> nodes_out x0=127, x1=-128 (saturation both rails).
REQ-034 DT=1, y={-1,-2,-2,-2}, vy=0 -> sum -7, com_out y=-1 (truncate toward zero); y all 127 -> com_out y=127.
REQ-035 begin_in pulsed in cycles 3 and 16 of a running operation -> both ignored, single result_out pulse; begin_in in cycle 17 -> new operation accepted.
REQ-036 rst_in=0 during cycle 7 of an operation -> all outputs 0, busy_out=0 next cycle, no result_out; subsequent begin_in with REQ-032 stimulus -> REQ-032 results.

Source files
------------

// File: rtl/integrate_positions_if.sv
// Bundles the start/data/result signals of the position integrator.
// Master drives begin and node/velocity arrays; slave returns positions, COM and status.
interface integrate_positions_if #(
   parameter int NUM_NODES     = 10,
   parameter int POSITION_SIZE = 8,
   parameter int VELOCITY_SIZE = 8
);
   logic                            begin_in;
   logic signed [POSITION_SIZE-1:0] nodes_in      [2][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] velocities_in [2][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] nodes_out     [2][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] com_out       [2];
   logic                            busy_out;
   logic                            result_out;

   modport master (
      output begin_in, nodes_in, velocities_in,
      input  nodes_out, com_out, busy_out, result_out
   );

   modport slave (
      input  begin_in, nodes_in, velocities_in,
      output nodes_out, com_out, busy_out, result_out
   );
endinterface

// File: rtl/integrate_positions.sv
// Integrates node positions by velocity*DT with saturation, one node per cycle,
// then divides the per-axis position sums by NUM_NODES to produce the centre of mass.
module integrate_positions #(
   parameter int NUM_NODES     = 10,
   parameter int POSITION_SIZE = 8,
   parameter int VELOCITY_SIZE = 8,
   parameter int DT            = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   integrate_positions_if.slave  bus
);
   localparam int SUM_SIZE  = POSITION_SIZE + $clog2(NUM_NODES) + 1;
   localparam int FULL_SIZE = POSITION_SIZE + VELOCITY_SIZE + 32;
   localparam int IDX_W     = $clog2(NUM_NODES);
   localparam int REM_W     = IDX_W + 1;
   localparam int STEP_W    = $clog2(SUM_SIZE + 1);

   localparam logic [REM_W-1:0]              DIVISOR = REM_W'(NUM_NODES);
   localparam logic signed [FULL_SIZE-1:0]   DT_W    = FULL_SIZE'(DT);
   localparam logic signed [FULL_SIZE-1:0]   MAX_W   = {{(FULL_SIZE-POSITION_SIZE+1){1'b0}}, {(POSITION_SIZE-1){1'b1}}};
   localparam logic signed [FULL_SIZE-1:0]   MIN_W   = {{(FULL_SIZE-POSITION_SIZE+1){1'b1}}, {(POSITION_SIZE-1){1'b0}}};
   localparam logic signed [POSITION_SIZE-1:0] MAX_P = {1'b0, {(POSITION_SIZE-1){1'b1}}};
   localparam logic signed [POSITION_SIZE-1:0] MIN_P = {1'b1, {(POSITION_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, INTEGRATE, DIVIDE, DONE} state_t;

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [STEP_W-1:0]               step_q, step_d;
   logic signed [POSITION_SIZE-1:0] pos_q   [2][NUM_NODES], pos_d   [2][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] vel_q   [2][NUM_NODES], vel_d   [2][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] nodes_q [2][NUM_NODES], nodes_d [2][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] com_q   [2], com_d [2];
   logic signed [SUM_SIZE-1:0]      sum_q   [2], sum_d [2];
   logic [SUM_SIZE-1:0]             dvd_q   [2], dvd_d [2];
   logic [REM_W-1:0]                rem_q   [2], rem_d [2];
   logic                            busy_q, busy_d;
   logic                            result_q, result_d;

   logic signed [POSITION_SIZE-1:0] step_pos_s [2];
   logic [REM_W-1:0]                rem_sh_s   [2];
   logic                            quo_bit_s  [2];
   logic [SUM_SIZE-1:0]             quo_s      [2];

   // Full-precision pos + vel*DT, clamped to the signed position range.
   function automatic logic signed [POSITION_SIZE-1:0] sat_step(
      input logic signed [POSITION_SIZE-1:0] pos,
      input logic signed [VELOCITY_SIZE-1:0] vel
   );
      logic signed [FULL_SIZE-1:0] pos_w;
      logic signed [FULL_SIZE-1:0] vel_w;
      logic signed [FULL_SIZE-1:0] sum_w;
      logic signed [POSITION_SIZE-1:0] res;
      pos_w = FULL_SIZE'(pos);
      vel_w = FULL_SIZE'(vel);
      sum_w = pos_w + vel_w * DT_W;
      if (sum_w > MAX_W) begin
         res = MAX_P;
      end else if (sum_w < MIN_W) begin
         res = MIN_P;
      end else begin
         res = POSITION_SIZE'(sum_w);
      end
      return res;
   endfunction

   // Next-state, integration datapath and restoring divider.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      step_d   = step_q;
      pos_d    = pos_q;
      vel_d    = vel_q;
      nodes_d  = nodes_q;
      com_d    = com_q;
      sum_d    = sum_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      for (int a = 0; a < 2; a++) begin
         step_pos_s[a] = {POSITION_SIZE{1'b0}};
         rem_sh_s[a]   = {REM_W{1'b0}};
         quo_bit_s[a]  = 1'b0;
         quo_s[a]      = {SUM_SIZE{1'b0}};
      end

      case (state_q)
         IDLE: begin
            if (bus.begin_in) begin
               pos_d   = bus.nodes_in;
               vel_d   = bus.velocities_in;
               idx_d   = {IDX_W{1'b0}};
               sum_d[0] = {SUM_SIZE{1'b0}};
               sum_d[1] = {SUM_SIZE{1'b0}};
               state_d = INTEGRATE;
            end else begin
               state_d = IDLE;
            end
         end
         INTEGRATE: begin
            for (int a = 0; a < 2; a++) begin
               step_pos_s[a]       = sat_step(pos_q[a][idx_q], vel_q[a][idx_q]);
               nodes_d[a][idx_q]   = step_pos_s[a];
               sum_d[a]            = sum_q[a] + SUM_SIZE'(step_pos_s[a]);
            end
            if (idx_q == IDX_W'(NUM_NODES - 1)) begin
               step_d  = {STEP_W{1'b0}};
               state_d = DIVIDE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = INTEGRATE;
            end
         end
         DIVIDE: begin
            // Step 0 loads |sum|; steps 1..SUM_SIZE each retire one quotient bit.
            if (step_q == {STEP_W{1'b0}}) begin
               for (int a = 0; a < 2; a++) begin
                  if (sum_q[a][SUM_SIZE-1]) begin
                     dvd_d[a] = $unsigned(-sum_q[a]);
                  end else begin
                     dvd_d[a] = $unsigned(sum_q[a]);
                  end
                  rem_d[a] = {REM_W{1'b0}};
               end
               step_d  = STEP_W'(1);
               state_d = DIVIDE;
            end else begin
               for (int a = 0; a < 2; a++) begin
                  rem_sh_s[a] = (rem_q[a] << 1) | REM_W'(dvd_q[a][SUM_SIZE-1]);
                  if (rem_sh_s[a] >= DIVISOR) begin
                     rem_d[a]     = rem_sh_s[a] - DIVISOR;
                     quo_bit_s[a] = 1'b1;
                  end else begin
                     rem_d[a]     = rem_sh_s[a];
                     quo_bit_s[a] = 1'b0;
                  end
                  quo_s[a] = {dvd_q[a][SUM_SIZE-2:0], quo_bit_s[a]};
                  dvd_d[a] = quo_s[a];
               end
               if (step_q == STEP_W'(SUM_SIZE)) begin
                  for (int a = 0; a < 2; a++) begin
                     if (sum_q[a][SUM_SIZE-1]) begin
                        com_d[a] = POSITION_SIZE'(-quo_s[a]);
                     end else begin
                        com_d[a] = POSITION_SIZE'(quo_s[a]);
                     end
                  end
                  state_d = DONE;
               end else begin
                  step_d  = step_q + STEP_W'(1);
                  state_d = DIVIDE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d   = (state_d != IDLE);
      result_d = (state_d == DONE);
   end

   // Register bank; the synchronous reset clears every visible output and the accumulators.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q  <= IDLE;
         idx_q    <= {IDX_W{1'b0}};
         step_q   <= {STEP_W{1'b0}};
         busy_q   <= 1'b0;
         result_q <= 1'b0;
         for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < NUM_NODES; k++) begin
               pos_q[a][k]   <= {POSITION_SIZE{1'b0}};
               vel_q[a][k]   <= {VELOCITY_SIZE{1'b0}};
               nodes_q[a][k] <= {POSITION_SIZE{1'b0}};
            end
            com_q[a] <= {POSITION_SIZE{1'b0}};
            sum_q[a] <= {SUM_SIZE{1'b0}};
            dvd_q[a] <= {SUM_SIZE{1'b0}};
            rem_q[a] <= {REM_W{1'b0}};
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         step_q   <= step_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         pos_q    <= pos_d;
         vel_q    <= vel_d;
         nodes_q  <= nodes_d;
         com_q    <= com_d;
         sum_q    <= sum_d;
         dvd_q    <= dvd_d;
         rem_q    <= rem_d;
      end
   end

   assign bus.nodes_out  = nodes_q;
   assign bus.com_out    = com_q;
   assign bus.busy_out   = busy_q;
   assign bus.result_out = result_q;
endmodule

// File: tb/tb_integrate_positions.sv
// Randomised and directed bench for integrate_positions (4 nodes, 8-bit, DT=2)
// against a cycle-scheduled arithmetic model of the integrator and its COM.
module tb_integrate_positions;
   localparam int N    = 4;
   localparam int P    = 8;
   localparam int V    = 8;
   localparam int DT   = 2;
   localparam int SUMW = P + $clog2(N) + 1;
   localparam int LAT  = N + SUMW + 1;
   localparam int PMAX = (1 << (P - 1)) - 1;
   localparam int PMIN = -(1 << (P - 1));

   logic clk_in = 1'b0;
   logic rst_in;

   integrate_positions_if #(.NUM_NODES(N), .POSITION_SIZE(P), .VELOCITY_SIZE(V)) bus ();

   integrate_positions #(.NUM_NODES(N), .POSITION_SIZE(P), .VELOCITY_SIZE(V), .DT(DT)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   int t = -1;
   int nxt_nodes [2][N];
   int nxt_com   [2];
   int exp_nodes [2][N];
   int exp_com   [2];
   int mv, ms;

   int sp [2][N];
   int sv [2][N];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
      end
   endtask

   // Model: on acceptance compute every result with plain integer maths, then reveal
   // node k one cycle after it is processed and the COM at the fixed latency.
   always @(posedge clk_in) begin
      if (!rst_in) begin
         t = -1;
         for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < N; k++) exp_nodes[a][k] = 0;
            exp_com[a] = 0;
         end
      end else if (t < 0) begin
         if (bus.begin_in) begin
            for (int a = 0; a < 2; a++) begin
               ms = 0;
               for (int k = 0; k < N; k++) begin
                  mv = int'(bus.nodes_in[a][k]) + int'(bus.velocities_in[a][k]) * DT;
                  if (mv > PMAX) mv = PMAX;
                  if (mv < PMIN) mv = PMIN;
                  nxt_nodes[a][k] = mv;
                  ms += mv;
               end
               nxt_com[a] = ms / N;
            end
            t = 0;
         end
      end else if (t == LAT) begin
         t = -1;
      end else begin
         t++;
         if (t <= N) begin
            for (int a = 0; a < 2; a++) exp_nodes[a][t-1] = nxt_nodes[a][t-1];
         end
         if (t == LAT) begin
            for (int a = 0; a < 2; a++) exp_com[a] = nxt_com[a];
         end
      end
   end

   // Compare every output against the model in the middle of every cycle.
   always @(negedge clk_in) begin
      if (chk_en) begin
         chk("busy_out", int'(bus.busy_out), (t >= 0) ? 1 : 0);
         chk("result_out", int'(bus.result_out), (t == LAT) ? 1 : 0);
         for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < N; k++)
               chk($sformatf("nodes_out[%0d][%0d]", a, k), int'(bus.nodes_out[a][k]), exp_nodes[a][k]);
            chk($sformatf("com_out[%0d]", a), int'(bus.com_out[a]), exp_com[a]);
         end
      end
   end

   task automatic scramble();
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < N; k++) begin
            bus.nodes_in[a][k]      = P'($urandom);
            bus.velocities_in[a][k] = V'($urandom);
         end
      end
   endtask

   task automatic clear_stim();
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < N; k++) begin
            sp[a][k] = 0;
            sv[a][k] = 0;
         end
      end
   endtask

   // Drive stimulus with begin high for one cycle; returns at the negedge of cycle 0.
   task automatic start_op();
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < N; k++) begin
            bus.nodes_in[a][k]      = P'(sp[a][k]);
            bus.velocities_in[a][k] = V'(sv[a][k]);
         end
      end
      bus.begin_in = 1'b1;
      @(negedge clk_in);
      bus.begin_in = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         scramble();
         @(negedge clk_in);
      end
   endtask

   task automatic set_stim_032();
      clear_stim();
      sp[0] = '{0, 10, 20, 30};
      sv[0] = '{1, 2, 3, 4};
   endtask

   task automatic check_032_results(input string tag);
      int ex [N] = '{2, 14, 26, 38};
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s_x%0d", tag, k), int'(bus.nodes_out[0][k]), ex[k]);
         chk($sformatf("%s_y%0d", tag, k), int'(bus.nodes_out[1][k]), 0);
      end
      chk({tag, "_comx"}, int'(bus.com_out[0]), 20);
      chk({tag, "_comy"}, int'(bus.com_out[1]), 0);
   endtask

   task automatic run_req032(input string tag);
      set_stim_032();
      start_op();
      for (int c = 0; c <= LAT + 1; c++) begin
         chk({tag, "_result_cyc"}, int'(bus.result_out), (c == 16) ? 1 : 0);
         if (c <= LAT) begin
            scramble();
            @(negedge clk_in);
         end
      end
      chk({tag, "_busy_end"}, int'(bus.busy_out), 0);
      check_032_results(tag);
   endtask

   initial begin
      int pulses;
      rst_in       = 1'b0;
      bus.begin_in = 1'b0;
      scramble();
      repeat (2) @(negedge clk_in);
      chk_en = 1'b1;
      chk("rst_busy", int'(bus.busy_out), 0);
      chk("rst_result", int'(bus.result_out), 0);
      chk("rst_node", int'(bus.nodes_out[1][N-1]), 0);
      chk("rst_com", int'(bus.com_out[0]), 0);
      rst_in = 1'b1;
      run_cycles(2);

      run_req032("r032");
      run_cycles(3);

      // Saturation on both rails.
      clear_stim();
      sp[0][0] = 120;  sv[0][0] = 10;
      sp[0][1] = -120; sv[0][1] = -20;
      start_op();
      run_cycles(LAT + 1);
      chk("sat_hi", int'(bus.nodes_out[0][0]), 127);
      chk("sat_lo", int'(bus.nodes_out[0][1]), -128);

      // COM truncates toward zero.
      clear_stim();
      sp[1] = '{-1, -2, -2, -2};
      start_op();
      run_cycles(LAT + 1);
      chk("com_trunc", int'(bus.com_out[1]), -1);

      // Extreme sums at both ends of the range.
      clear_stim();
      sp[1] = '{127, 127, 127, 127};
      sp[0] = '{-128, -128, -128, -128};
      sv[0] = '{-128, -128, -128, -128};
      start_op();
      run_cycles(LAT + 1);
      chk("com_max", int'(bus.com_out[1]), 127);
      chk("com_min", int'(bus.com_out[0]), -128);
      chk("node_min", int'(bus.nodes_out[0][3]), -128);

      // begin in cycles 3 and 16 ignored; begin in cycle 17 accepted.
      set_stim_032();
      start_op();
      pulses = 0;
      for (int c = 0; c <= 18; c++) begin
         if (bus.result_out) pulses++;
         if (c == 17) check_032_results("ign");
         if (c == 18) chk("accept_after_done", int'(bus.busy_out), 1);
         scramble();
         bus.begin_in = (c == 3 || c == 16 || c == 17);
         @(negedge clk_in);
      end
      bus.begin_in = 1'b0;
      chk("single_pulse", pulses, 1);
      run_cycles(LAT + 2);

      // Reset in cycle 7 aborts the operation.
      set_stim_032();
      start_op();
      for (int c = 0; c < 7; c++) begin
         scramble();
         @(negedge clk_in);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("abort_busy", int'(bus.busy_out), 0);
      chk("abort_node", int'(bus.nodes_out[0][2]), 0);
      chk("abort_com", int'(bus.com_out[0]), 0);
      rst_in = 1'b1;
      pulses = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         if (bus.result_out) pulses++;
         scramble();
         @(negedge clk_in);
      end
      chk("abort_no_result", pulses, 0);
      run_req032("post_rst");

      // Random traffic: random data every cycle, random begin and occasional reset.
      for (int i = 0; i < 1500; i++) begin
         scramble();
         bus.begin_in = ($urandom_range(0, 5) == 0);
         rst_in       = ($urandom_range(0, 119) != 0);
         @(negedge clk_in);
      end
      rst_in       = 1'b1;
      bus.begin_in = 1'b0;
      run_cycles(LAT + 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
